// File: rtl/bit_run_encoder.sv
// Run-length encoder for a single-bit stream: emits {bit, length} tokens through a
// registered valid/ready output slot. Define BIT_RUN_ENCODER_FLUSH_EN to add a flush input.
module bit_run_encoder #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [CNT_W-1:0] out_len
`ifdef BIT_RUN_ENCODER_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   localparam logic [CNT_W-1:0] MAX = '1;

   typedef enum logic {StIdle, StRun} state_e;

   state_e           state_q;
   logic             cur_bit_q;
   logic [CNT_W-1:0] cnt_q;

   logic flush_req;
   logic slot_free;
   logic accept;
   logic same_bit;
   logic saturated;
   logic emit_beat;
   logic emit_flush;
   logic emit;

`ifdef BIT_RUN_ENCODER_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // The output slot can take a new token if empty or being drained this cycle.
   assign slot_free = !out_valid || out_ready;
   assign in_ready  = slot_free && !flush_req;
   assign accept    = in_valid && in_ready;

   assign same_bit  = (in_bit == cur_bit_q);
   assign saturated = (cnt_q == MAX);

   // A run closes on a bit change, or when a matching beat would overflow the counter.
   assign emit_beat  = (state_q == StRun) && accept && (!same_bit || saturated);
   assign emit_flush = (state_q == StRun) && flush_req && slot_free;
   assign emit       = emit_beat || emit_flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cur_bit_q <= 1'b0;
         cnt_q     <= '0;
         out_valid <= 1'b0;
         out_bit   <= 1'b0;
         out_len   <= '0;
      end else begin
         if (emit) begin
            out_valid <= 1'b1;
            out_bit   <= cur_bit_q;
            out_len   <= cnt_q;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q   <= StRun;
                  cur_bit_q <= in_bit;
                  cnt_q     <= CNT_W'(1);
               end
            end
            StRun: begin
               if (emit_flush) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (accept) begin
                  if (emit_beat) begin
                     cur_bit_q <= in_bit;
                     cnt_q     <= CNT_W'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
